// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions, TX state encoding and the FSM
// observation struct.
package uart_pkg;

  // Register offsets within the 16-byte window
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN_BIT = 0;

  // TX state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Complete transmitter FSM state, kept in one struct so checkers can
  // bind to a single signal.
  typedef struct packed {
    logic [1:0]  state;
    logic [2:0]  bit_idx;
    logic [15:0] bit_cnt;
  } tx_fsm_t;

  function automatic logic [31:0] pack_status(input logic full,
                                              input logic empty,
                                              input logic busy);
    logic [31:0] v;
    v                   = '0;
    v[STATUS_FULL_BIT]  = full;
    v[STATUS_EMPTY_BIT] = empty;
    v[STATUS_BUSY_BIT]  = busy;
    return v;
  endfunction

  function automatic logic [31:0] pack_ctrl(input logic irq_en);
    logic [31:0] v;
    v                  = '0;
    v[CTRL_IRQ_EN_BIT] = irq_en;
    return v;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. DEPTH must be a power
// of two so the pointers wrap naturally. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter on a CPU native bus.
// Optional feature macro: UART_TX_IRQ_EN (CTRL register at 0x8 and tx_irq).
//
// Bus handshake: the master raises mem_valid with address/data/strobes and
// holds them until mem_ready. mem_ready is a registered one-cycle pulse
// issued the cycle after a decision; while it is high no new decision is
// taken, so consecutive completions are always separated by a low cycle.
// A TXDATA push into a full FIFO withholds the decision until a pop frees
// an entry in the same cycle.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          CLK_DIV    = 104,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic                        sel;
  logic [3:0]                  offset;
  logic                        is_write;
  logic                        push_req;
  logic                        stall;
  logic                        accept;
  logic [31:0]                 read_val;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [7:0]                  fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
  logic                        tx_busy;
  logic                        bit_end;
  logic                        line_next;
  logic                        irq_en;
  logic [7:0]                  shifter;
  tx_fsm_t                     fsm;
  logic                        unused_bits;

  assign unused_bits = ^mem_wdata[31:8];

  assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = mem_addr[3:0];
  assign is_write  = |mem_wstrb;
  assign push_req  = is_write && (offset == OFF_TXDATA) && mem_wstrb[0];
  assign stall     = push_req && fifo_full && !fifo_pop;
  assign accept    = sel && !mem_ready && !stall;
  assign fifo_push = accept && push_req;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (fifo_push),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  // Register read mux; unmapped and write-only offsets read as zero
  always_comb begin
    read_val = '0;
    case (offset)
      OFF_STATUS: read_val = pack_status(fifo_full, fifo_empty, tx_busy);
      OFF_CTRL:   read_val = pack_ctrl(irq_en);
      default:    read_val = '0;
    endcase
  end

  // Bus completion: one-cycle ready pulse, read data valid only with it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_write) ? read_val : '0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  // CTRL register write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      irq_en_q <= 1'b0;
    end else if (accept && is_write && (offset == OFF_CTRL) && mem_wstrb[0]) begin
      irq_en_q <= mem_wdata[CTRL_IRQ_EN_BIT];
    end
  end

  // Interrupt is registered, so it trails the idle/empty condition by a cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) irq_q <= 1'b0;
    else       irq_q <= irq_en_q & fifo_empty & ~tx_busy;
  end

  assign irq_en = irq_en_q;
  assign tx_irq = irq_q;
`else
  assign irq_en = 1'b0;
  assign tx_irq = 1'b0;
`endif

  assign tx_busy  = (fsm.state != ST_IDLE);
  assign bit_end  = (fsm.bit_cnt == DIV_M1);
  assign fifo_pop = !fifo_empty &&
                    ((fsm.state == ST_IDLE) || ((fsm.state == ST_STOP) && bit_end));

  // TX state machine: each bit lasts CLK_DIV cycles; back-to-back frames
  // chain from STOP straight into START
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsm     <= '{state: ST_IDLE, bit_idx: 3'd0, bit_cnt: 16'd0};
      shifter <= '0;
    end else begin
      case (fsm.state)
        ST_IDLE: begin
          if (fifo_pop) begin
            shifter     <= fifo_head;
            fsm.bit_cnt <= '0;
            fsm.state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            fsm.bit_cnt <= '0;
            fsm.bit_idx <= '0;
            fsm.state   <= ST_DATA;
          end else begin
            fsm.bit_cnt <= fsm.bit_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            fsm.bit_cnt <= '0;
            if (fsm.bit_idx == 3'd7) fsm.state   <= ST_STOP;
            else                     fsm.bit_idx <= fsm.bit_idx + 3'd1;
          end else begin
            fsm.bit_cnt <= fsm.bit_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            fsm.bit_cnt <= '0;
            if (fifo_pop) begin
              shifter   <= fifo_head;
              fsm.state <= ST_START;
            end else begin
              fsm.state <= ST_IDLE;
            end
          end else begin
            fsm.bit_cnt <= fsm.bit_cnt + 16'd1;
          end
        end
        default: fsm.state <= ST_IDLE;
      endcase
    end
  end

  // Serial level implied by the current state
  always_comb begin
    line_next = 1'b1;
    case (fsm.state)
      ST_START: line_next = 1'b0;
      ST_DATA:  line_next = shifter[fsm.bit_idx];
      default:  line_next = 1'b1;
    endcase
  end

  // Registered line driver keeps uart_tx glitch-free and high in reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) uart_tx <= 1'b1;
    else       uart_tx <= line_next;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLK_DIV=4, FIFO_DEPTH=4.
// Serial frames and read data are checked by monitors against queues
// filled by the stimulus.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        uart_tx;
  logic        tx_irq;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .uart_tx   (uart_tx),
    .tx_irq    (tx_irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  int          start_q[$];
  int          frames_done  = 0;
  int          last_end_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: condition not met (got false, expected true)", name);
  endtask

  // ---------------- serial monitor ----------------
  logic       mon_busy = 1'b0;
  int         mon_cyc  = 0;
  int         mon_bit  = 0;
  logic       mon_bad  = 1'b0;
  logic [7:0] mon_byte = '0;

  always @(negedge clk) begin
    if (!nrst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 0;
        mon_bad  = 1'b0;
        mon_byte = '0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cyc++;
      mon_bit = mon_cyc / 4;
      if (mon_bit == 0) begin
        if (uart_tx !== 1'b0) mon_bad = 1'b1;
      end else if (mon_bit <= 8) begin
        if (mon_cyc % 4 == 0) mon_byte[mon_bit-1] = uart_tx;
        else if (uart_tx !== mon_byte[mon_bit-1]) mon_bad = 1'b1;
      end else begin
        if (uart_tx !== 1'b1) mon_bad = 1'b1;
      end
      if (mon_cyc == 39) begin
        check("frame_shape", {31'd0, mon_bad}, 32'd0);
        if (exp_q.size() == 0) fail("unexpected_frame");
        else check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        frames_done++;
        last_end_cyc = cyc;
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- read-data monitor ----------------
  always @(negedge clk) begin
    if (nrst && mem_ready && mem_wstrb == 4'd0) begin
      if (rd_exp_q.size() == 0) fail("unexpected_read");
      else check(rd_name_q.pop_front(), mem_rdata, rd_exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+1; returns at posedge+1 after the ready cycle.
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output int rcyc);
    int n;
    n = 0;
    rcyc = -1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    while (rcyc < 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (mem_ready) rcyc = cyc;
    end
    if (rcyc < 0) fail("bus_timeout");
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int r;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus_xfer(addr, 32'd0, 4'd0, r);
  endtask

  task automatic wait_frames(input int n);
    int k;
    k = 0;
    while (frames_done < n && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (frames_done < n) fail("frame_timeout");
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, r1, r5, r6, s0, f0, rise;
    logic seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    check("reset_tx_irq", {31'd0, tx_irq}, 32'd0);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(BASE + 32'h4, 32'h2, "status_after_reset");

    // Single byte 0x55: start bit 2 cycles after ready, STATUS empty after
    s0 = start_q.size();
    f0 = frames_done;
    exp_q.push_back(8'h55);
    bus_xfer(BASE, 32'h55, 4'b0001, r);
    wait_frames(f0 + 1);
    if (start_q.size() > s0) check("start_latency", start_q[s0] - r, 32'd2);
    else fail("start_latency");
    bus_read(BASE + 32'h4, 32'h2, "status_after_frame");

    // Back-to-back frames: second start right after the first stop
    s0 = start_q.size();
    f0 = frames_done;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    bus_xfer(BASE, 32'hA5, 4'b0001, r);
    bus_xfer(BASE, 32'h3C, 4'b0001, r);
    wait_frames(f0 + 2);
    if (start_q.size() >= s0 + 2) check("b2b_gap", start_q[s0+1] - start_q[s0], 32'd40);
    else fail("b2b_gap");

    // Full-FIFO stall: write 6 is held until the frame-2 pop
    f0 = frames_done;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h77);
    bus_xfer(BASE, 32'h11, 4'b0001, r1);
    bus_xfer(BASE, 32'h22, 4'b0001, r);
    bus_xfer(BASE, 32'h33, 4'b0001, r);
    bus_xfer(BASE, 32'h44, 4'b0001, r);
    bus_xfer(BASE, 32'h66, 4'b0001, r5);
    check("write5_no_stall", r5 - r1, 32'd8);
    bus_read(BASE + 32'h4, 32'h5, "status_full");
    bus_xfer(BASE, 32'h77, 4'b0001, r6);
    check("stall_release", r6 - r1, 32'd41);
    wait_frames(f0 + 6);

`ifdef UART_TX_IRQ_EN
    // Interrupt: high when idle and enabled, low in frame, rises after idle
    bus_xfer(BASE + 32'h8, 32'h1, 4'b0001, r);
    bus_read(BASE + 32'h8, 32'h1, "ctrl_readback");
    @(negedge clk);
    check("irq_idle_high", {31'd0, tx_irq}, 32'd1);
    @(posedge clk);
    #1;
    f0 = frames_done;
    exp_q.push_back(8'hC3);
    bus_xfer(BASE, 32'hC3, 4'b0001, r);
    idle(20);
    @(negedge clk);
    check("irq_low_in_frame", {31'd0, tx_irq}, 32'd0);
    rise = -1;
    for (int k = 0; k < 200 && rise < 0; k++) begin
      @(negedge clk);
      if (tx_irq) rise = cyc;
    end
    if (rise < 0) fail("irq_rise_timeout");
    else check("irq_rise", rise - last_end_cyc, 32'd1);
    @(posedge clk);
    #1;
    wait_frames(f0 + 1);
    bus_xfer(BASE + 32'h8, 32'h0, 4'b0001, r);
    @(negedge clk);
    check("irq_cleared", {31'd0, tx_irq}, 32'd0);
    @(posedge clk);
    #1;
`else
    // Without the interrupt feature CTRL is absent and tx_irq stays low
    bus_xfer(BASE + 32'h8, 32'h1, 4'b0001, r);
    bus_read(BASE + 32'h8, 32'h0, "ctrl_absent");
    @(negedge clk);
    check("irq_tied_low", {31'd0, tx_irq}, 32'd0);
    @(posedge clk);
    #1;
`endif

    // Address decode: outside the window never completes
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h10;
    mem_wstrb = 4'd0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    check("decode_miss_ready", {31'd0, seen}, 32'd0);
    check("decode_miss_rdata", mem_rdata, 32'd0);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    @(posedge clk);
    #1;
    bus_read(BASE + 32'hC, 32'h0, "read_rsvd");
    bus_read(BASE + 32'h0, 32'h0, "read_txdata");

    // Ignored writes produce no frames
    s0 = start_q.size();
    bus_xfer(BASE, 32'h77, 4'b0010, r);
    bus_xfer(BASE + 32'h4, 32'hFF, 4'b1111, r);
    bus_xfer(BASE + 32'hC, 32'h99, 4'b0001, r);
    idle(60);
    check("ignored_writes_no_frame", start_q.size() - s0, 32'd0);
    bus_read(BASE + 32'h4, 32'h2, "status_after_ignored");

    // Reset in the middle of a DATA bit with a second byte queued
    bus_xfer(BASE, 32'hF0, 4'b0001, r);
    bus_xfer(BASE, 32'h0F, 4'b0001, r);
    idle(10);
    #2 nrst = 1'b0;
    #1;
    check("reset_line_high", {31'd0, uart_tx}, 32'd1);
    check("reset_ready_low", {31'd0, mem_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    s0 = start_q.size();
    bus_read(BASE + 32'h4, 32'h2, "status_after_midreset");
    idle(100);
    check("no_residual_frames", start_q.size() - s0, 32'd0);

    // Queues drained
    idle(2);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("rd_q_drained", rd_exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, meaning base of the 16-byte register window; bits [3:0] are ignored.
REQ-002 SHALL have parameter CLK_DIV, default 104, meaning clk cycles per UART bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of TX byte entries, a power of two in the range 2..16.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mem_valid, input, 1, the CPU native-bus request.
REQ-007 SHALL have port mem_addr, input, 32, the byte address.
REQ-008 SHALL have port mem_wdata, input, 32, the write data.
REQ-009 SHALL have port mem_wstrb, input, 4, the byte write strobes; all-zero means a read.
REQ-010 SHALL have port mem_ready, output, 1, the completion strobe.
REQ-011 SHALL have port mem_rdata, output, 32, the read data.
REQ-012 SHALL have port uart_tx, output, 1, the serial line, idle high.
REQ-013 SHALL have port tx_irq, output, 1, the interrupt request to the CPU irq vector.

Function
REQ-014 SHALL select the block when mem_valid=1 and mem_addr[31:4]==BASE_ADDR[31:4]; when not selected, mem_ready=0 and mem_rdata=0.
REQ-015 SHALL pulse mem_ready high for exactly one cycle to complete a selected transfer, no earlier than the cycle after selection, and SHALL deassert it for at least one cycle before the next completion; mem_valid and the other inputs are held by the master until ready.
REQ-016 SHALL push mem_wdata[7:0] into the FIFO on a write to offset 0x0 with mem_wstrb[0]=1; if the FIFO is full, mem_ready SHALL stay low (stall) until an entry frees, and the push and ready SHALL then occur in the same cycle.
REQ-017 SHALL accept a push into a full FIFO in the same cycle as a pop.
REQ-018 SHALL ignore writes to offset 0x0 with mem_wstrb[0]=0 and writes to offsets 0x4 and 0xC; all of these complete normally.
REQ-019 SHALL return, on a read of offset 0x4, STATUS with bit0 = fifo_full, bit1 = fifo_empty, bit2 = tx_busy, and all other bits 0.
REQ-020 SHALL return 0 on reads of offsets 0x0 and 0xC.
REQ-021 SHALL implement a TX state machine with states IDLE, START, DATA, STOP.
REQ-022 SHALL, in IDLE, pop the FIFO head when the FIFO is non-empty and enter START on the next cycle.
REQ-023 SHALL transmit one frame as a low start bit, then 8 data bits LSB first, then a high stop bit, each bit lasting exactly CLK_DIV cycles, for a frame of 10*CLK_DIV cycles.
REQ-024 SHALL, at the end of STOP, pop the next byte if the FIFO is non-empty and go directly to START with no idle gap, otherwise return to IDLE.
REQ-025 SHALL drive tx_busy=1 whenever the state is not IDLE.
REQ-026 SHALL use a 16-bit bit-period counter and a 3-bit bit index, with the FIFO pointers wrapping modulo FIFO_DEPTH and an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-027 SHALL make the first start-bit cycle on uart_tx appear 2 cycles after the mem_ready that pushed a byte into an empty FIFO with the state machine IDLE.

Reset
REQ-028 SHALL, while nrst=0, asynchronously force uart_tx=1, mem_ready=0, mem_rdata=0, tx_irq=0, the FIFO empty with pointers at 0, the state IDLE, the counters at 0, and the CTRL register at 0.
REQ-029 SHALL abort any frame in progress on reset and discard all queued bytes; after release, the block starts idle with the line high.

Configuration
REQ-030 SHALL, with UART_TX_IRQ_EN defined, implement CTRL at offset 0x8, where bit0 = irq_en is written when mem_wstrb[0]=1 and read back in bit0.
REQ-031 SHALL, with UART_TX_IRQ_EN defined, register tx_irq = irq_en & fifo_empty & ~tx_busy, so that it lags the condition by one cycle.
REQ-032 SHALL, without UART_TX_IRQ_EN defined, read offset 0x8 as 0, ignore writes to it, and tie tx_irq to 0, with the port still present.

Structure
REQ-033 SHALL place the register offsets (0x0, 0x4, 0x8), the STATUS and CTRL bit positions, and the TX state encoding in the shared package uart_pkg.
REQ-034 SHALL implement the FIFO as the sub-module uart_tx_fifo, a synchronous FIFO with push, pop, full, empty and count, parameterised by its depth.

Verification
REQ-035 SHALL verify single byte: CLK_DIV=4, write 0x55 to 0x0 -> uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles; frame = 40 cycles, and STATUS=0x2 afterwards.
REQ-036 SHALL verify back-to-back: write 0xA5 then 0x3C -> the second start bit begins on the cycle immediately after the first stop bit ends.
REQ-037 SHALL verify full-FIFO stall: FIFO_DEPTH=4, six writes issued back-to-back -> the 6th write's mem_ready is withheld until the frame-2 pop, STATUS bit0=1 while full, and all 6 bytes emerge in order.
REQ-038 SHALL verify irq: UART_TX_IRQ_EN defined, CTRL=1, send 1 byte -> tx_irq=0 during the frame and rises 1 cycle after returning to IDLE; writing CTRL=0 drops it.
REQ-039 SHALL verify reset mid-frame: nrst low during a DATA bit -> uart_tx=1 immediately, STATUS=0x2 after release, and no residual bytes are sent.
REQ-040 SHALL verify address decode: a read at BASE_ADDR+0x10 -> mem_ready stays 0; a read at BASE_ADDR+0xC -> ready with rdata=0.
